dct2_row_sched: RTL and testbench
=================================

Name: dct2_row_sched

Overview:
- Sequences one transform block, row by row, through the shared 1-D DCT-II datapath (sizes 4/8/16/32).
- Latches the block size, accepts one 512-bit row per valid/ready handshake and drives the datapath input and size select.
- Waits the datapath latency, captures the result and presents it downstream with valid/ready, row index and a last flag.
- Sits between the row-fetch buffer and the transposition/second-pass stage.

Parameters:
- VEC_W, 512, width of a row vector (32 samples x 16 bits, sample 0 in MSBs).
- DP_LAT, 1, cycles from dp_x/dp_n stable to dp_y valid; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a block; sampled in IDLE only.
- cfg_n  in  2  size code sampled with start: 00=4, 01=8, 10=16, 11=32 (rows per block = 4<<cfg_n).
- abort  in  1  synchronous cancel of the current block.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last row's output handshake.
- in_valid  in  1  row available.
- in_ready  out  1  scheduler accepts a row.
- in_data  in  VEC_W  input row.
- dp_x  out  VEC_W  datapath input row (registered).
- dp_n  out  2  datapath size select (registered).
- dp_y  in  VEC_W  datapath output row.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts.
- out_data  out  VEC_W  result row (registered).
- out_row  out  5  row index of out_data within the block.
- out_last  out  1  out_data is the final row of the block.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: busy, done, in_ready, out_valid and out_last go to 0; dp_x, dp_n, out_data and out_row go to 0.
  - Internal: state=IDLE, row counter=0, latency counter=0.
- FSM states: IDLE, WAIT_ROW, CALC, OUT.
- IDLE:
  - start=1 latches cfg_n into dp_n, clears the row counter and moves to WAIT_ROW.
  - Any other input is ignored.
- WAIT_ROW:
  - in_ready=1.
  - On in_valid&&in_ready: dp_x<=in_data, latency counter<=DP_LAT-1, next state CALC.
- CALC:
  - in_ready=0; the latency counter decrements each cycle.
  - When it is 0, out_data<=dp_y, out_row<=row counter, and out_last<=(row counter==(4<<dp_n)-1). Next state is OUT.
  - Total: the in handshake at cycle t gives out_valid=1 at cycle t+DP_LAT+1.
- OUT:
  - out_valid=1. out_data, out_row and out_last are held stable while out_ready=0.
  - On handshake with out_last=0: row counter increments and the state returns to WAIT_ROW.
  - On handshake with out_last=1: done=1 for one cycle and the state returns to IDLE. done is registered and asserted in the cycle after the handshake.
- Sustained rate: one row per DP_LAT+2 cycles when in_valid and out_ready are held high.
- Datapath stability: dp_n is constant from start until return to IDLE. dp_x holds its last value outside CALC.
- start while busy: ignored, with no change to dp_n.
- abort:
  - Any state other than IDLE goes to IDLE on the next edge.
  - out_valid and in_ready drop that same edge; done is not pulsed.
  - abort has priority over a simultaneous handshake; the handshake does not complete.
  - abort in IDLE has no effect, and abort together with start in IDLE means abort wins.
- Row count wrap: the 5-bit counter never exceeds 31 (size 32, last row index 31); no wrap beyond the block.
- Reset mid-block: immediate return to reset values; a partial block is discarded.
- busy is a registered decode of state!=IDLE.

Decomposition:
- Shared package dct2_pkg:
  - Size-code typedef (enum DCT4/DCT8/DCT16/DCT32 = 2'b00..2'b11).
  - FSM state typedef.
  - Constants VEC_W=512, SAMPLE_W=16.
  - Function rows_of(code) returning 4<<code.
- No sub-module is needed: the FSM, counters and registers sit in one module. The datapath is instantiated by the parent, not inside this block.

Test Plan:
- Size 4, DP_LAT=1: start with cfg_n=00, push 4 rows (sample0 = 1,2,3,4, all else 0), out_ready=1 and a dp_y model equal to dp_x.
  - Required: 4 outputs with out_row 0..3 and out_last only on row 3.
  - done pulses one cycle after the 4th handshake; each output comes 2 cycles after its input handshake.
- Size 32, DP_LAT=3, continuous valid/ready: 32 outputs with the last at row 31.
  - Input handshakes are spaced 5 cycles apart; dp_n=11 throughout; busy falls the cycle after done.
- Backpressure, size 8: hold out_ready=0 for 10 cycles on row 2.
  - out_data and out_row=2 are stable; in_ready=0; no row is lost; the 8 rows complete.
- Abort in CALC of row 5, size 16: next cycle state=IDLE, out_valid=0, no done.
  - A following start with cfg_n=00 runs 4 clean rows.
- start pulsed mid-block with a different cfg_n: ignored, dp_n unchanged, block completes with the original row count.
- rst_n asserted while in OUT: out_valid, busy and done go to 0 immediately; all output registers go to 0; after release only start is honoured.

Source files
------------

// File: rtl/dct2_pkg.sv
// Shared types and constants for the 1-D DCT-II row scheduling logic.
package dct2_pkg;

  localparam int VEC_W    = 512;
  localparam int SAMPLE_W = 16;

  // Transform size code: rows per block = 4 << code
  typedef enum logic [1:0] {
    DCT4  = 2'b00,
    DCT8  = 2'b01,
    DCT16 = 2'b10,
    DCT32 = 2'b11
  } size_e;

  // Row scheduler FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_ROW = 2'b01,
    CALC     = 2'b10,
    OUT      = 2'b11
  } state_e;

  // Number of rows in a block of the given size (4..32, fits in 6 bits)
  function automatic logic [5:0] rows_of(input size_e code);
    return 6'd4 << code;
  endfunction

endpackage

// File: rtl/dct2_row_sched.sv
// Row scheduler for the shared 1-D DCT-II datapath: latches the block size,
// feeds one row at a time into the datapath, waits its fixed latency and
// hands the result downstream with row index and last-row flag.
module dct2_row_sched #(
  parameter int VEC_W  = dct2_pkg::VEC_W,
  parameter int DP_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       cfg_n,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_data,
  output logic [VEC_W-1:0] dp_x,
  output logic [1:0]       dp_n,
  input  logic [VEC_W-1:0] dp_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_data,
  output logic [4:0]       out_row,
  output logic             out_last
);
  import dct2_pkg::*;

  // Latency counter preload: counts DP_LAT-1 .. 0 inside CALC
  localparam logic [2:0] LAT_INIT = 3'(DP_LAT - 1);

  state_e             state_q,    state_d;
  logic [4:0]         row_q,      row_d;
  logic [2:0]         lat_q,      lat_d;
  logic [VEC_W-1:0]   dp_x_q,     dp_x_d;
  size_e              dp_n_q,     dp_n_d;
  logic [VEC_W-1:0]   out_data_q, out_data_d;
  logic [4:0]         out_row_q,  out_row_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;

  // Next-state and next-output decode for the scheduler FSM
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    lat_d      = lat_q;
    dp_x_d     = dp_x_q;
    dp_n_d     = dp_n_q;
    out_data_d = out_data_q;
    out_row_d  = out_row_q;
    out_last_d = out_last_q;
    done_d     = 1'b0;

    if (abort && (state_q != IDLE)) begin
      // Cancel wins over any handshake in flight; no done pulse
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            dp_n_d  = size_e'(cfg_n);
            row_d   = 5'd0;
            state_d = WAIT_ROW;
          end
        end
        WAIT_ROW: begin
          if (in_valid && in_ready_q) begin
            dp_x_d  = in_data;
            lat_d   = LAT_INIT;
            state_d = CALC;
          end
        end
        CALC: begin
          if (lat_q == 3'd0) begin
            out_data_d = dp_y;
            out_row_d  = row_q;
            out_last_d = ({1'b0, row_q} == (rows_of(dp_n_q) - 6'd1));
            state_d    = OUT;
          end else begin
            lat_d = lat_q - 3'd1;
          end
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              // Never wraps: the last row of a 32-row block ends the block above
              row_d   = row_q + 5'd1;
              state_d = WAIT_ROW;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Handshake outputs are registered decodes of the state being entered
    out_valid_d = (state_d == OUT);
    in_ready_d  = (state_d == WAIT_ROW);
    // busy trails the state register by one cycle
    busy_d      = (state_q != IDLE);
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= 5'd0;
      lat_q       <= 3'd0;
      dp_x_q      <= '0;
      dp_n_q      <= DCT4;
      out_data_q  <= '0;
      out_row_q   <= 5'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      lat_q       <= lat_d;
      dp_x_q      <= dp_x_d;
      dp_n_q      <= dp_n_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign in_ready  = in_ready_q;
  assign dp_x      = dp_x_q;
  assign dp_n      = dp_n_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct2_row_sched.sv
// Bench for dct2_row_sched: two instances (DP_LAT=1 and DP_LAT=3) share the
// stimulus; sel picks which one the checks look at.
module tb_dct2_row_sched;
  localparam int W = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] cfg_n = 2'b00;
  logic [W-1:0] in_data;
  logic sel = 1'b0;

  logic busy1, done1, in_ready1, out_valid1, out_last1;
  logic [W-1:0] dp_x1, dp_y1, out_data1;
  logic [1:0] dp_n1;
  logic [4:0] out_row1;
  logic busy3, done3, in_ready3, out_valid3, out_last3;
  logic [W-1:0] dp_x3, dp_y3, out_data3;
  logic [1:0] dp_n3;
  logic [4:0] out_row3;

  always #5 clk = ~clk;

  dct2_row_sched #(.VEC_W(W), .DP_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n(cfg_n), .abort(abort),
    .busy(busy1), .done(done1), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .dp_x(dp_x1), .dp_n(dp_n1), .dp_y(dp_y1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_row(out_row1), .out_last(out_last1));

  dct2_row_sched #(.VEC_W(W), .DP_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n(cfg_n), .abort(abort),
    .busy(busy3), .done(done3), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .dp_x(dp_x3), .dp_n(dp_n3), .dp_y(dp_y3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_row(out_row3), .out_last(out_last3));

  // Identity datapath model
  assign dp_y1 = dp_x1;
  assign dp_y3 = dp_x3;

  logic busy_s, done_s, in_ready_s, out_valid_s, out_last_s;
  logic [W-1:0] dp_x_s, out_data_s;
  logic [1:0] dp_n_s;
  logic [4:0] out_row_s;
  assign busy_s      = sel ? busy3      : busy1;
  assign done_s      = sel ? done3      : done1;
  assign in_ready_s  = sel ? in_ready3  : in_ready1;
  assign out_valid_s = sel ? out_valid3 : out_valid1;
  assign out_last_s  = sel ? out_last3  : out_last1;
  assign dp_x_s      = sel ? dp_x3      : dp_x1;
  assign out_data_s  = sel ? out_data3  : out_data1;
  assign dp_n_s      = sel ? dp_n3      : dp_n1;
  assign out_row_s   = sel ? out_row3   : out_row1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Row k of a block carries sample0 = k+1, all other samples 0
  logic mon_clr = 1'b0;
  int in_idx = 0;
  always @(posedge clk) begin
    if (mon_clr) in_idx <= 0;
    else if (in_valid && in_ready_s) in_idx <= in_idx + 1;
  end
  assign in_data = {16'(in_idx + 1), {(W-16){1'b0}}};

  // Handshake / event recorder, sampled on the falling edge
  int in_cnt = 0, out_cnt = 0, done_cnt = 0, dpn_bad = 0;
  int done_t = -1, busy_fall_t = -1;
  logic busy_prev = 1'b0;
  logic [1:0] dpn_exp = 2'b00;
  int in_t[64];
  int out_t[64];
  logic [W-1:0] od[64];
  logic [4:0] orow[64];
  logic olast[64];
  always @(negedge clk) begin
    busy_prev <= busy_s;
    if (mon_clr) begin
      in_cnt <= 0; out_cnt <= 0; done_cnt <= 0; dpn_bad <= 0;
      done_t <= -1; busy_fall_t <= -1;
    end else begin
      if (in_valid && in_ready_s) begin
        if (in_cnt < 64) in_t[in_cnt] <= cyc;
        in_cnt <= in_cnt + 1;
      end
      if (out_valid_s && out_ready) begin
        if (out_cnt < 64) begin
          out_t[out_cnt] <= cyc;
          od[out_cnt]    <= out_data_s;
          orow[out_cnt]  <= out_row_s;
          olast[out_cnt] <= out_last_s;
        end
        out_cnt <= out_cnt + 1;
      end
      if (done_s) begin
        done_cnt <= done_cnt + 1;
        done_t   <= cyc;
      end
      if (busy_s && (dp_n_s != dpn_exp)) dpn_bad <= dpn_bad + 1;
      if (busy_prev && !busy_s) busy_fall_t <= cyc;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; abort = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr();
  endtask

  task automatic start_blk(input logic [1:0] c);
    cfg_n = c;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tg, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk({tg, " done seen"}, W'(done_cnt != 0), W'(1));
    tick(3);
  endtask

  // Compare recorded outputs against the expected row sequence
  task automatic chk_rows(input string tg, input int n, input int lat);
    logic [W-1:0] e;
    chk({tg, " out count"}, W'(out_cnt), W'(n));
    for (int i = 0; i < n && i < 64; i++) begin
      e = '0;
      e[W-1 -: 16] = 16'(i + 1);
      chk($sformatf("%s data[%0d]", tg, i), od[i], e);
      chk($sformatf("%s row[%0d]", tg, i), W'(orow[i]), W'(i));
      chk($sformatf("%s last[%0d]", tg, i), W'(olast[i]), W'(i == n - 1));
      if (lat >= 0)
        chk($sformatf("%s latency[%0d]", tg, i), W'(out_t[i] - in_t[i]), W'(lat + 1));
    end
    chk({tg, " done count"}, W'(done_cnt), W'(1));
    if (n > 0 && n <= 64)
      chk({tg, " done timing"}, W'(done_t), W'(out_t[n-1] + 1));
  endtask

  typedef struct {
    logic [15:0] s0;
    logic [4:0]  row;
    logic        last;
    int          lat;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[4];
    int k;
    logic stable;
    logic [W-1:0] e3;

    tv[0] = '{16'd1, 5'd0, 1'b0, 2};
    tv[1] = '{16'd2, 5'd1, 1'b0, 2};
    tv[2] = '{16'd3, 5'd2, 1'b0, 2};
    tv[3] = '{16'd4, 5'd3, 1'b1, 2};

    // Reset values on both instances
    rst_n = 1'b0;
    tick(2);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("reset busy[%0d]", s), W'(busy_s), W'(0));
      chk($sformatf("reset done[%0d]", s), W'(done_s), W'(0));
      chk($sformatf("reset in_ready[%0d]", s), W'(in_ready_s), W'(0));
      chk($sformatf("reset out_valid[%0d]", s), W'(out_valid_s), W'(0));
      chk($sformatf("reset out_last[%0d]", s), W'(out_last_s), W'(0));
      chk($sformatf("reset dp_x[%0d]", s), dp_x_s, '0);
      chk($sformatf("reset dp_n[%0d]", s), W'(dp_n_s), W'(0));
      chk($sformatf("reset out_data[%0d]", s), out_data_s, '0);
      chk($sformatf("reset out_row[%0d]", s), W'(out_row_s), W'(0));
    end

    // Size 4, DP_LAT=1, table-driven
    sel = 1'b0;
    do_reset();
    dpn_exp = 2'b00;
    in_valid = 1'b1; out_ready = 1'b1;
    start_blk(2'b00);
    wait_done("s4", 100);
    chk("s4 out count", W'(out_cnt), W'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s4 sample0[%0d]", i), W'(od[i][W-1 -: 16]), W'(tv[i].s0));
      chk($sformatf("s4 rest[%0d]", i), W'(od[i][W-17:0]), '0);
      chk($sformatf("s4 row[%0d]", i), W'(orow[i]), W'(tv[i].row));
      chk($sformatf("s4 last[%0d]", i), W'(olast[i]), W'(tv[i].last));
      chk($sformatf("s4 latency[%0d]", i), W'(out_t[i] - in_t[i]), W'(tv[i].lat));
    end
    chk("s4 done count", W'(done_cnt), W'(1));
    chk("s4 done timing", W'(done_t), W'(out_t[3] + 1));

    // Size 32, DP_LAT=3, continuous flow
    sel = 1'b1;
    do_reset();
    dpn_exp = 2'b11;
    in_valid = 1'b1; out_ready = 1'b1;
    start_blk(2'b11);
    wait_done("s32", 400);
    chk_rows("s32", 32, 3);
    for (int i = 0; i < 31; i++)
      chk($sformatf("s32 in spacing[%0d]", i), W'(in_t[i+1] - in_t[i]), W'(5));
    chk("s32 dp_n stable", W'(dpn_bad), W'(0));
    chk("s32 busy fall", W'(busy_fall_t), W'(done_t + 1));
    chk("s32 busy low", W'(busy_s), W'(0));

    // Backpressure on row 2, size 8
    sel = 1'b0;
    do_reset();
    dpn_exp = 2'b01;
    in_valid = 1'b1; out_ready = 1'b1;
    start_blk(2'b01);
    k = 0;
    while (out_cnt < 2 && k < 100) begin tick(1); k++; end
    out_ready = 1'b0;
    k = 0;
    while (!out_valid_s && k < 20) begin tick(1); k++; end
    chk("bp row2 valid", W'(out_valid_s), W'(1));
    e3 = '0;
    e3[W-1 -: 16] = 16'd3;
    stable = 1'b1;
    repeat (10) begin
      if (!out_valid_s || out_row_s != 5'd2 || out_data_s != e3 || in_ready_s) stable = 1'b0;
      tick(1);
    end
    chk("bp hold stable", W'(stable), W'(1));
    chk("bp no extra out", W'(out_cnt), W'(2));
    out_ready = 1'b1;
    wait_done("bp", 200);
    chk_rows("bp", 8, -1);

    // Abort during CALC of row 5, size 16, then a clean size-4 block
    sel = 1'b0;
    do_reset();
    dpn_exp = 2'b10;
    in_valid = 1'b1; out_ready = 1'b1;
    start_blk(2'b10);
    k = 0;
    while (in_idx < 6 && k < 200) begin tick(1); k++; end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort out_valid", W'(out_valid_s), W'(0));
    chk("abort in_ready", W'(in_ready_s), W'(0));
    chk("abort out count", W'(out_cnt), W'(5));
    tick(3);
    chk("abort no accept", W'(in_idx), W'(6));
    chk("abort busy", W'(busy_s), W'(0));
    chk("abort no done", W'(done_cnt), W'(0));
    dpn_exp = 2'b00;
    clr();
    start_blk(2'b00);
    wait_done("post-abort", 100);
    chk_rows("post-abort", 4, 1);

    // start mid-block with a different size is ignored
    sel = 1'b0;
    do_reset();
    dpn_exp = 2'b01;
    in_valid = 1'b1; out_ready = 1'b1;
    start_blk(2'b01);
    k = 0;
    while (out_cnt < 3 && k < 100) begin tick(1); k++; end
    start_blk(2'b11);
    chk("midstart dp_n", W'(dp_n_s), W'(1));
    wait_done("midstart", 200);
    chk_rows("midstart", 8, 1);
    chk("midstart dp_n stable", W'(dpn_bad), W'(0));

    // Reset asserted while in OUT
    sel = 1'b0;
    do_reset();
    dpn_exp = 2'b00;
    in_valid = 1'b1; out_ready = 1'b0;
    start_blk(2'b00);
    k = 0;
    while (!out_valid_s && k < 20) begin tick(1); k++; end
    chk("rst-out reached OUT", W'(out_valid_s), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst-out out_valid", W'(out_valid_s), W'(0));
    chk("rst-out busy", W'(busy_s), W'(0));
    chk("rst-out done", W'(done_s), W'(0));
    chk("rst-out in_ready", W'(in_ready_s), W'(0));
    chk("rst-out out_data", out_data_s, '0);
    chk("rst-out out_row", W'(out_row_s), W'(0));
    chk("rst-out out_last", W'(out_last_s), W'(0));
    chk("rst-out dp_x", dp_x_s, '0);
    chk("rst-out dp_n", W'(dp_n_s), W'(0));
    tick(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(4);
    chk("rst-out no accept", W'(in_idx), W'(1));
    chk("rst-out idle", W'(busy_s), W'(0));
    clr();
    start_blk(2'b00);
    wait_done("post-rst", 100);
    chk_rows("post-rst", 4, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
